sccb_config_seq: RTL and testbench
==================================

// Module: sccb_config_seq
// PURPOSE
//  Walks the SCCB register ROM after reset or on request. Turns each 16-bit entry {reg,data} into one write
//  transaction on the SCCB master. Handles the 0xFFF0 delay marker and the 0xFFFF end marker. Retries NACKed writes.
//  Sits between the camera-config ROM and the SCCB master; config_done gates the camera capture path.
// PARAMETERS
//  DELAY_CYCLES  1_000_000  clk cycles waited on a 0xFFF0 entry (10 ms @100 MHz)
//  GAP_CYCLES    100        idle clk cycles between consecutive SCCB writes
//  MAX_RETRY     3          re-attempts per entry after sccb_nack before abort
//  AUTO_START    1          1: start sequence automatically on reset release
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   pulse: (re)start sequence from addr 0; ignored while busy
//  rom_addr       out  8   ROM address
//  rom_dout       in   16  ROM data, valid 1 clk after rom_addr changes (registered ROM)
//  sccb_ready     in   1   SCCB master idle, can accept a write
//  sccb_start     out  1   1-clk pulse: launch write of sccb_reg/sccb_data
//  sccb_reg       out  8   register address (rom_dout[15:8])
//  sccb_data      out  8   register data (rom_dout[7:0])
//  sccb_done      in   1   1-clk pulse: transaction finished
//  sccb_nack      in   1   qualifies sccb_done: slave did not ACK
//  config_busy    out  1   sequence in progress
//  config_done    out  1   level: last sequence reached 0xFFFF without abort
//  config_err     out  1   level: last sequence aborted after MAX_RETRY
// BEHAVIOUR
//  Reset: rom_addr=0, sccb_start=0, sccb_reg=0, sccb_data=0, config_busy=0, config_done=0, config_err=0.
//  Internal counters clear. State = IDLE.
//  The first clk after reset release: if AUTO_START=1, IDLE->FETCH as if start were pulsed.
//  FSM states: IDLE, FETCH, DECODE, ISSUE, WAIT, GAP, DELAY, FINISH.
//   IDLE:   on start -> FETCH. rom_addr=0, retry=0, config_done=0, config_err=0, config_busy=1.
//   FETCH:  one wait clk for ROM latency -> DECODE.
//   DECODE: rom_dout==FFFF -> FINISH; ==FFF0 -> DELAY. Otherwise latch sccb_reg/sccb_data -> ISSUE.
//   ISSUE:  wait for sccb_ready=1, then pulse sccb_start for exactly 1 clk -> WAIT.
//   WAIT:   on sccb_done & !sccb_nack -> GAP. retry=0, rom_addr+1.
//           On sccb_done & sccb_nack with retry<MAX_RETRY -> GAP. retry+1, same addr.
//           On sccb_done & sccb_nack with retry==MAX_RETRY -> IDLE. config_err=1, config_busy=0.
//   GAP:    count GAP_CYCLES clks -> FETCH. GAP_CYCLES=0 means no extra clks.
//   DELAY:  count DELAY_CYCLES clks, then rom_addr+1 -> FETCH.
//   FINISH: config_done=1, config_busy=0 -> IDLE.
//  Address wrap: if rom_addr==255 and a write/delay completes, treat as end-of-ROM (FINISH); never wrap to 0.
//  start while config_busy=1 is ignored. start and sccb_done in the same clk: sccb_done is processed, start dropped.
//  sccb_done outside WAIT is ignored.
//  The reset input is the only abort; it may assert mid-transaction. Outputs go to reset values immediately.
//  The SCCB master is responsible for its own line recovery.
//  Counters are sized $clog2(max(DELAY_CYCLES,GAP_CYCLES)+1). No combinational path from sccb_* inputs to sccb_start.
//  Min per-write time: FETCH+DECODE+ISSUE = 3 clks + SCCB time + GAP_CYCLES.
// TESTING (bench with DELAY_CYCLES=20, GAP_CYCLES=2, MAX_RETRY=3; model ROM + SCCB master)
//  1. ROM {1280,FFF0,1214,FFFF}, AUTO_START=1, always ACK.
//     -> writes (12,80) then (12,14). >=20 clks between done#1 and start#2.
//     -> config_done=1 after FFFF. Exactly 2 sccb_start pulses.
//  2. sccb_ready held 0 for 50 clks at ISSUE -> sccb_start stays 0. It pulses on the 1st clk after ready rises.
//  3. NACK entry 1 twice, then ACK -> 3 starts with (12,14). No address skip. config_done=1, config_err=0.
//  4. NACK entry 0 always -> exactly 4 starts. config_err=1, config_busy=0, config_done=0. rom_addr stays 0.
//  5. ROM without FFFF (all 256 entries = 0x4010) -> 256 writes. FINISH at addr 255. rom_addr never returns to 0.
//  6. Assert reset during WAIT of entry 2 -> all outputs reset same clk.
//     With AUTO_START=1, sequence restarts at addr 0. A start pulse while busy has no effect.

Source files
------------

// File: rtl/sccb_config_seq.sv
// Walks the SCCB register ROM and issues one SCCB write per {reg,data} entry.
// Handles the 0xFFF0 delay marker and the 0xFFFF end marker, and retries NACKed writes.
module sccb_config_seq #(
  parameter int DELAY_CYCLES = 1_000_000,
  parameter int GAP_CYCLES   = 100,
  parameter int MAX_RETRY    = 3,
  parameter int AUTO_START   = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_dout_i,
  input  logic        sccb_ready_i,
  output logic        sccb_start_o,
  output logic [7:0]  sccb_reg_o,
  output logic [7:0]  sccb_data_o,
  input  logic        sccb_done_i,
  input  logic        sccb_nack_i,
  output logic        config_busy_o,
  output logic        config_done_o,
  output logic        config_err_o
);

  localparam int CNT_MAX = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] DLY_LAST  = CW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, GAP, DELAY, FINISH} state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d, reg_q, reg_d, data_q, data_d;
  logic          start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          auto_q, auto_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      auto_q  <= (AUTO_START != 0);
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      auto_q  <= auto_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    data_d  = data_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    auto_d  = auto_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_i || auto_q) begin
        auto_d  = 1'b0;
        addr_d  = '0;
        retry_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_dout_i == 16'hFFFF) state_d = FINISH;
        else if (rom_dout_i == 16'hFFF0) begin
          cnt_d   = '0;
          state_d = DELAY;
        end else begin
          reg_d   = rom_dout_i[15:8];
          data_d  = rom_dout_i[7:0];
          state_d = ISSUE;
        end
      end
      // start is registered so sccb_ready never reaches sccb_start combinationally
      ISSUE: if (sccb_ready_i) begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (sccb_done_i) begin
        cnt_d = '0;
        if (!sccb_nack_i) begin
          retry_d = '0;
          if (addr_q == 8'hFF) state_d = FINISH;
          else begin
            addr_d  = addr_q + 8'd1;
            state_d = (GAP_CYCLES == 0) ? FETCH : GAP;
          end
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RW'(1);
          state_d = (GAP_CYCLES == 0) ? FETCH : GAP;
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = FETCH;
        else cnt_d = cnt_q + CW'(1);
      end
      DELAY: begin
        if (cnt_q == DLY_LAST) begin
          if (addr_q == 8'hFF) state_d = FINISH;
          else begin
            addr_d  = addr_q + 8'd1;
            state_d = FETCH;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr_o    = addr_q;
  assign sccb_start_o  = start_q;
  assign sccb_reg_o    = reg_q;
  assign sccb_data_o   = data_q;
  assign config_busy_o = busy_q;
  assign config_done_o = done_q;
  assign config_err_o  = err_q;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: registered ROM model plus a simple SCCB master with scripted NACKs.
module tb_sccb_config_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, ready_en = 1'b1;
  logic [7:0]  rom_addr, sccb_reg, sccb_data;
  logic [15:0] rom_dout;
  logic        sccb_ready, sccb_start, sccb_done, sccb_nack;
  logic        config_busy, config_done, config_err;

  logic [15:0] rom [256];
  int          nack_addr = 0, nack_n = 0;

  sccb_config_seq #(.DELAY_CYCLES(20), .GAP_CYCLES(2), .MAX_RETRY(3), .AUTO_START(1)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .rom_addr_o(rom_addr), .rom_dout_i(rom_dout),
    .sccb_ready_i(sccb_ready), .sccb_start_o(sccb_start),
    .sccb_reg_o(sccb_reg), .sccb_data_o(sccb_data),
    .sccb_done_i(sccb_done), .sccb_nack_i(sccb_nack),
    .config_busy_o(config_busy), .config_done_o(config_done), .config_err_o(config_err));

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom[rom_addr];

  // SCCB master: accepts a start while idle, answers done 3 clks later
  logic        mbusy, pend;
  int          mcnt, n_starts, n_hi, n_done, nack_used, cyc;
  logic        seen_nz, ret0;
  logic [15:0] log_w [512];
  int          start_cyc [4], done_cyc [4];

  assign sccb_ready = ready_en && !mbusy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbusy <= 0; pend <= 0; mcnt <= 0; n_starts <= 0; n_hi <= 0; n_done <= 0;
      nack_used <= 0; cyc <= 0; seen_nz <= 0; ret0 <= 0;
      sccb_done <= 0; sccb_nack <= 0;
    end else begin
      cyc <= cyc + 1;
      sccb_done <= 0;
      sccb_nack <= 0;
      if (config_busy && rom_addr != 0) seen_nz <= 1;
      if (config_busy && seen_nz && rom_addr == 0) ret0 <= 1;
      if (sccb_start) n_hi <= n_hi + 1;
      if (sccb_start && !mbusy) begin
        if (n_starts < 512) log_w[n_starts] <= {sccb_reg, sccb_data};
        if (n_starts < 4) start_cyc[n_starts] <= cyc;
        n_starts <= n_starts + 1;
        mbusy <= 1;
        mcnt <= 3;
        if (int'(rom_addr) == nack_addr && nack_used < nack_n) begin
          pend <= 1;
          nack_used <= nack_used + 1;
        end else pend <= 0;
      end else if (mbusy) begin
        if (mcnt == 1) begin
          sccb_done <= 1;
          sccb_nack <= pend;
          mbusy <= 0;
          if (n_done < 4) done_cyc[n_done] <= cyc;
          n_done <= n_done + 1;
        end
        mcnt <= mcnt - 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wait_idle(input int maxc, output bit to);
    bit saw = 0;
    to = 1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (config_busy) saw = 1;
      else if (saw) begin to = 0; break; end
    end
  endtask

  task automatic load_rom(input int kind);
    for (int i = 0; i < 256; i++) rom[i] = (kind == 1) ? 16'h4010 : 16'hFFFF;
    if (kind == 0) begin
      rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    end
  endtask

  task automatic restart(input int kind);
    @(negedge clk);
    reset = 1;
    load_rom(kind);
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    int          kind, nack_addr, nack_n, exp_starts;
    bit          exp_done, exp_err;
    int          exp_addr;
    logic [15:0] exp_first, exp_last;
    int          exp_n_last;
    bit          chk_gap;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit to;
    int cnt, bad;
    vecs[0] = '{0, 0, 0,   2,   1, 0, 3,   16'h1280, 16'h1214, 1,   1};
    vecs[1] = '{0, 2, 2,   4,   1, 0, 3,   16'h1280, 16'h1214, 3,   0};
    vecs[2] = '{0, 0, 100, 4,   0, 1, 0,   16'h1280, 16'h1280, 4,   0};
    vecs[3] = '{1, 0, 0,   256, 1, 0, 255, 16'h4010, 16'h4010, 256, 0};

    load_rom(0);
    #1;
    chk("reset_addr", int'(rom_addr), 0);
    chk("reset_outs", int'({sccb_start, sccb_reg, sccb_data, config_busy, config_done, config_err}), 0);

    foreach (vecs[v]) begin
      nack_addr = vecs[v].nack_addr;
      nack_n    = vecs[v].nack_n;
      restart(vecs[v].kind);
      wait_idle(6000, to);
      chk($sformatf("v%0d_timeout", v), int'(to), 0);
      chk($sformatf("v%0d_starts", v), n_starts, vecs[v].exp_starts);
      chk($sformatf("v%0d_start_hi", v), n_hi, vecs[v].exp_starts);
      chk($sformatf("v%0d_done", v), int'(config_done), int'(vecs[v].exp_done));
      chk($sformatf("v%0d_err", v), int'(config_err), int'(vecs[v].exp_err));
      chk($sformatf("v%0d_busy", v), int'(config_busy), 0);
      chk($sformatf("v%0d_addr", v), int'(rom_addr), vecs[v].exp_addr);
      chk($sformatf("v%0d_ret0", v), int'(ret0), 0);
      chk($sformatf("v%0d_first", v), int'(log_w[0]), int'(vecs[v].exp_first));
      cnt = 0;
      for (int i = 0; i < n_starts && i < 512; i++) if (log_w[i] == vecs[v].exp_last) cnt++;
      chk($sformatf("v%0d_n_last", v), cnt, vecs[v].exp_n_last);
      if (vecs[v].chk_gap)
        chk("v0_delay_gap", int'(start_cyc[1] - done_cyc[0] >= 20), 1);
    end

    // sccb_ready held low in ISSUE
    nack_n = 0;
    ready_en = 0;
    restart(0);
    repeat (53) @(negedge clk);
    chk("rdy_low_no_start", n_hi, 0);
    ready_en = 1;
    @(posedge clk); #1;
    chk("rdy_rise_start", int'(sccb_start), 1);
    @(posedge clk); #1;
    chk("rdy_pulse_1clk", int'(sccb_start), 0);
    wait_idle(2000, to);
    chk("rdy_timeout", int'(to), 0);
    chk("rdy_done", int'(config_done), 1);
    chk("rdy_starts", n_starts, 2);

    // reset during WAIT of entry 2, then restart and ignore start while busy
    restart(1);
    to = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (n_starts == 3 && mbusy) begin to = 0; break; end
    end
    chk("mid_reach_wait", int'(to), 0);
    chk("mid_addr_pre", int'(rom_addr), 2);
    reset = 1;
    #1;
    chk("mid_reset_addr", int'(rom_addr), 0);
    chk("mid_reset_outs", int'({sccb_start, sccb_reg, sccb_data, config_busy, config_done, config_err}), 0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("mid_restart_busy", int'(config_busy), 1);
    to = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rom_addr == 3) begin to = 0; break; end
    end
    chk("mid_reach_addr3", int'(to), 0);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("busy_start_ignored", int'(rom_addr >= 3), 1);
    wait_idle(6000, to);
    chk("mid_timeout", int'(to), 0);
    chk("mid_done", int'(config_done), 1);
    chk("mid_starts", n_starts, 256);
    chk("mid_ret0", int'(ret0), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (log_w[i] != 16'h4010) bad++;
    chk("mid_payload", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
